lfsr_decrypt_sequencer: RTL and testbench

- Hardware accelerator for Program #2 (message decryption). Shares the data memory port with the core while the core is stalled.
- Recovers the LFSR seed and tap pattern from the known space-character preamble, then decrypts the 64-byte ciphertext to plaintext. Ciphertext is at DM[SRC_BASE..+63]; plaintext is written to DM[DST_BASE..+63].
- Instantiated beside DM1 in TopLevel, with the same Start/Ack handshake as TopLevel.

---
 rtl/lfsr_decrypt_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lfsr_decrypt_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_sequencer.sv
// Program #2 accelerator: recovers LFSR seed/tap from a space preamble, then decrypts DM[SRC_BASE..] into DM[DST_BASE..].
// Optional feature macro: PARITY_CHECK_EN (counts ciphertext bytes with bad parity in ParErrCnt).
module lfsr_decrypt_sequencer #(
  parameter logic [7:0] SRC_BASE  = 8'd64,
  parameter logic [7:0] DST_BASE  = 8'd0,
  parameter int         MSG_LEN   = 64,
  parameter int         PRE_CHECK = 10,
  parameter logic [7:0] SPACE     = 8'h20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData,
  output logic [3:0] TapSel,
  output logic       Found,
  output logic [6:0] ParErrCnt
);

  typedef enum logic [2:0] {IDLE, SEED, SEARCH, DEC_RD, DEC_WR, DONE, FAILED} state_t;

  state_t     state;
  logic       start_q;
  logic [6:0] seed;
  logic [6:0] srch_s;
  logic [3:0] pat;
  logic [7:0] idx;
  logic [6:0] lfsr;

  logic [6:0] rd7;
  logic [6:0] s_next;
  logic       launch;
  logic       launch_ok;

  function automatic logic [6:0] tap_rom(input logic [3:0] p);
    case (p)
      4'd0:    tap_rom = 7'h60;
      4'd1:    tap_rom = 7'h48;
      4'd2:    tap_rom = 7'h78;
      4'd3:    tap_rom = 7'h72;
      4'd4:    tap_rom = 7'h6A;
      4'd5:    tap_rom = 7'h69;
      4'd6:    tap_rom = 7'h5C;
      4'd7:    tap_rom = 7'h7E;
      4'd8:    tap_rom = 7'h7B;
      default: tap_rom = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] tap);
    step = {s[5:0], ^(s & tap)};
  endfunction

  assign rd7       = MemRdData[6:0];
  assign s_next    = step(srch_s, tap_rom(pat));
  assign launch    = start_q & ~Start;
  assign launch_ok = launch & ((state == IDLE) | (state == DONE) | (state == FAILED));

  // MemAddr is registered, so every transition also presents the address the next state reads.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      start_q   <= 1'b1;
      Ack       <= 1'b0;
      MemWrEn   <= 1'b0;
      MemAddr   <= 8'd0;
      MemWrData <= 8'd0;
      TapSel    <= 4'hF;
      Found     <= 1'b0;
      seed      <= 7'd0;
      srch_s    <= 7'd0;
      pat       <= 4'd0;
      idx       <= 8'd0;
      lfsr      <= 7'd0;
    end else begin
      start_q <= Start;
      MemWrEn <= 1'b0;
      case (state)
        IDLE, DONE, FAILED: begin
          if (launch) begin
            Ack     <= 1'b0;
            Found   <= 1'b0;
            TapSel  <= 4'hF;
            MemAddr <= SRC_BASE;
            state   <= SEED;
          end
        end
        SEED: begin
          seed    <= rd7 ^ SPACE[6:0];
          srch_s  <= rd7 ^ SPACE[6:0];
          pat     <= 4'd0;
          idx     <= 8'd1;
          MemAddr <= SRC_BASE + 8'd1;
          if ((rd7 ^ SPACE[6:0]) == 7'd0) begin
            Ack   <= 1'b1;
            state <= FAILED;
          end else begin
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if ((rd7 ^ s_next) == SPACE[6:0]) begin
            if (idx == 8'(PRE_CHECK - 1)) begin
              TapSel  <= pat;
              Found   <= 1'b1;
              lfsr    <= seed;
              idx     <= 8'd0;
              MemAddr <= SRC_BASE;
              state   <= DEC_RD;
            end else begin
              srch_s  <= s_next;
              idx     <= idx + 8'd1;
              MemAddr <= SRC_BASE + idx + 8'd1;
            end
          end else if (pat == 4'd8) begin
            Ack   <= 1'b1;
            state <= FAILED;
          end else begin
            pat     <= pat + 4'd1;
            srch_s  <= seed;
            idx     <= 8'd1;
            MemAddr <= SRC_BASE + 8'd1;
          end
        end
        DEC_RD: begin
          MemAddr   <= DST_BASE + idx;
          MemWrEn   <= 1'b1;
          MemWrData <= {1'b0, rd7 ^ lfsr};
          state     <= DEC_WR;
        end
        DEC_WR: begin
          lfsr    <= step(lfsr, tap_rom(TapSel));
          idx     <= idx + 8'd1;
          MemAddr <= SRC_BASE + idx + 8'd1;
          if (idx == 8'(MSG_LEN - 1)) begin
            Ack   <= 1'b1;
            state <= DONE;
          end else begin
            state <= DEC_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic [6:0] par_cnt;

  // Bad-parity bytes are only counted; they are still decrypted and written.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      par_cnt <= 7'd0;
    end else if (launch_ok) begin
      par_cnt <= 7'd0;
    end else if ((state == DEC_RD) && (^MemRdData) && (par_cnt != 7'h7F)) begin
      par_cnt <= par_cnt + 7'd1;
    end
  end

  assign ParErrCnt = par_cnt;
`else
  logic unused_par;
  assign unused_par = MemRdData[7] ^ launch_ok;
  assign ParErrCnt  = 7'd0;
`endif

endmodule

// File: tb/tb_lfsr_decrypt_sequencer.sv
// Self-checking bench for lfsr_decrypt_sequencer: behavioural memory plus an arithmetic model of seed/tap search and decryption.
module tb_lfsr_decrypt_sequencer;

  localparam int SRC = 64;
  localparam int DST = 0;
  localparam int LEN = 64;
  localparam int PRE = 10;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;
  logic [3:0] TapSel;
  logic       Found;
  logic [6:0] ParErrCnt;

  logic [7:0] mem      [256];
  logic [7:0] load_buf [256];
  logic       load_req;
  int         pt       [LEN];
  int         tap_tbl  [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
  int         errors = 0;
  int         checks = 0;

  always #5 Clk = ~Clk;

  lfsr_decrypt_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData),
    .TapSel(TapSel), .Found(Found), .ParErrCnt(ParErrCnt)
  );

  assign MemRdData = mem[MemAddr];

  always @(posedge Clk) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= load_buf[a];
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
    end
  end

  // Reference model: plain integer arithmetic over the ciphertext image.
  function automatic int nxt(input int s, input int t);
    return ((s * 2) & 'h7F) | ($countones(s & t) % 2);
  endfunction

  function automatic int seed_of();
    return (int'(load_buf[SRC]) & 'h7F) ^ 'h20;
  endfunction

  function automatic int model_tap();
    int s;
    bit ok;
    if (seed_of() == 0) return -1;
    for (int p = 0; p < 9; p++) begin
      s  = seed_of();
      ok = 1'b1;
      for (int i = 1; i < PRE; i++) begin
        s = nxt(s, tap_tbl[p]);
        if (((int'(load_buf[SRC + i]) & 'h7F) ^ s) != 'h20) begin
          ok = 1'b0;
          break;
        end
      end
      if (ok) return p;
    end
    return -1;
  endfunction

  function automatic int exp_plain(input int k, input int p);
    int l = seed_of();
    for (int j = 0; j < k; j++) l = nxt(l, tap_tbl[p]);
    return (int'(load_buf[SRC + k]) & 'h7F) ^ l;
  endfunction

  function automatic int bad_plain(input int p);
    int cnt = 0;
    for (int k = 0; k < LEN; k++)
      if (mem[DST + k] !== 8'(exp_plain(k, p))) cnt++;
    return cnt;
  endfunction

  function automatic int changed_dst();
    int cnt = 0;
    for (int k = 0; k < LEN; k++)
      if (mem[DST + k] !== load_buf[DST + k]) cnt++;
    return cnt;
  endfunction

  function automatic int model_par();
    int cnt = 0;
`ifdef PARITY_CHECK_EN
    for (int k = 0; k < LEN; k++)
      if ($countones(load_buf[SRC + k]) % 2 != 0) cnt++;
    if (cnt > 127) cnt = 127;
`endif
    return cnt;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_random_pt();
    for (int k = 0; k < LEN; k++) pt[k] = (k < PRE) ? 'h20 : int'($urandom_range(32, 126));
  endtask

  // Destination bytes get bit 7 set so any byte the DUT fails to write stands out.
  task automatic build(input int t, input int seed);
    int l;
    int c;
    for (int a = 0; a < 256; a++) load_buf[a] = 8'($urandom);
    for (int k = 0; k < LEN; k++) load_buf[DST + k] = load_buf[DST + k] | 8'h80;
    l = seed;
    for (int k = 0; k < LEN; k++) begin
      c = (pt[k] ^ l) & 'h7F;
      load_buf[SRC + k] = 8'(c | (($countones(c) % 2) << 7));
      l = nxt(l, tap_tbl[t]);
    end
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic run(output int cyc, output bit to);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 0;
    to  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      tick();
      cyc++;
      if (Ack === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL ack_timeout: Ack=%0b after %0d cycles, required 1", Ack, cyc);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b1;
    repeat (3) tick();
    checks += 7;
    if (Ack !== 1'b0)       begin errors++; $display("[TB] FAIL reset_ack: got %0b need 0", Ack); end
    if (MemWrEn !== 1'b0)   begin errors++; $display("[TB] FAIL reset_wren: got %0b need 0", MemWrEn); end
    if (MemAddr !== 8'd0)   begin errors++; $display("[TB] FAIL reset_addr: got %0h need 0", MemAddr); end
    if (MemWrData !== 8'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %0h need 0", MemWrData); end
    if (TapSel !== 4'hF)    begin errors++; $display("[TB] FAIL reset_tapsel: got %0h need f", TapSel); end
    if (Found !== 1'b0)     begin errors++; $display("[TB] FAIL reset_found: got %0b need 0", Found); end
    if (ParErrCnt !== 7'd0) begin errors++; $display("[TB] FAIL reset_parcnt: got %0d need 0", ParErrCnt); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic load_known_message();
    string msg = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < LEN; k++) pt[k] = 'h20;
    for (int k = 0; k < msg.len(); k++) pt[PRE + k] = int'(msg[k]);
    build(3, 'h01);
    load_mem();
  endtask

  task automatic test_start_hold();
    bit saw_wr = 1'b0;
    bit saw_ack = 1'b0;
    bit done = 1'b0;
    load_known_message();
    Start = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      saw_wr  |= (MemWrEn === 1'b1);
      saw_ack |= (Ack === 1'b1);
    end
    checks += 3;
    if (saw_wr)  begin errors++; $display("[TB] FAIL hold_wren: got 1 need 0"); end
    if (saw_ack) begin errors++; $display("[TB] FAIL hold_ack: got 1 need 0"); end
    Start = 1'b0;
    tick();
    if (MemAddr !== 8'(SRC)) begin errors++; $display("[TB] FAIL launch_addr: got %0h need %0h", MemAddr, SRC); end
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      done = (Ack === 1'b1);
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL hold_run_timeout: Ack=%0b need 1", Ack); end
  endtask

  task automatic test_known_message();
    int cyc;
    bit to;
    int bad;
    load_known_message();
    run(cyc, to);
    bad = bad_plain(3);
    checks += 8;
    if (Found !== 1'b1)      begin errors++; $display("[TB] FAIL known_found: got %0b need 1", Found); end
    if (TapSel !== 4'd3)     begin errors++; $display("[TB] FAIL known_tapsel: got %0d need 3", TapSel); end
    if (TapSel !== 4'(model_tap())) begin errors++; $display("[TB] FAIL known_model_tap: got %0d need %0d", TapSel, model_tap()); end
    if (cyc > 1 + 9 * 9 + 128 + 2) begin errors++; $display("[TB] FAIL known_latency: got %0d need <= 212", cyc); end
    if (mem[0] !== 8'h20)    begin errors++; $display("[TB] FAIL known_dm0: got %0h need 20", mem[0]); end
    if (mem[10] !== 8'h4D)   begin errors++; $display("[TB] FAIL known_dm10: got %0h need 4d", mem[10]); end
    if (bad !== 0)           begin errors++; $display("[TB] FAIL known_bytes: %0d wrong bytes, need 0", bad); end
    if (ParErrCnt !== 7'd0)  begin errors++; $display("[TB] FAIL known_parcnt: got %0d need 0", ParErrCnt); end
  endtask

  task automatic test_all_taps();
    int cyc;
    bit to;
    int exp_t;
    for (int t = 0; t < 9; t++) begin
      fill_random_pt();
      build(t, 'h55);
      load_mem();
      run(cyc, to);
      exp_t = model_tap();
      checks += 3;
      if (Found !== 1'b1) begin errors++; $display("[TB] FAIL taps_found[%0d]: got %0b need 1", t, Found); end
      if (TapSel !== 4'(exp_t)) begin errors++; $display("[TB] FAIL taps_tapsel[%0d]: got %0d need %0d", t, TapSel, exp_t); end
      if (bad_plain(exp_t) !== 0) begin errors++; $display("[TB] FAIL taps_bytes[%0d]: %0d wrong bytes, need 0", t, bad_plain(exp_t)); end
    end
  endtask

  task automatic test_zero_seed();
    int cyc;
    bit to;
    fill_random_pt();
    build(int'($urandom_range(0, 8)), int'($urandom_range(1, 127)));
    load_buf[SRC] = 8'h20;
    load_mem();
    run(cyc, to);
    checks += 4;
    if (Ack !== 1'b1)     begin errors++; $display("[TB] FAIL zero_ack: got %0b need 1", Ack); end
    if (Found !== 1'b0)   begin errors++; $display("[TB] FAIL zero_found: got %0b need 0", Found); end
    if (TapSel !== 4'hF)  begin errors++; $display("[TB] FAIL zero_tapsel: got %0h need f", TapSel); end
    if (changed_dst() !== 0) begin errors++; $display("[TB] FAIL zero_dst: %0d bytes changed, need 0", changed_dst()); end
  endtask

  task automatic test_parity();
    int cyc;
    bit to;
    int exp_t;
    fill_random_pt();
    build(int'($urandom_range(0, 8)), int'($urandom_range(1, 127)));
    load_buf[100] = load_buf[100] ^ 8'h80;
    load_buf[101] = load_buf[101] ^ 8'h80;
    load_mem();
    run(cyc, to);
    exp_t = model_tap();
    checks += 3;
    if (ParErrCnt !== 7'(model_par())) begin errors++; $display("[TB] FAIL par_count: got %0d need %0d", ParErrCnt, model_par()); end
    if (mem[36] !== 8'(exp_plain(36, exp_t))) begin errors++; $display("[TB] FAIL par_dm36: got %0h need %0h", mem[36], exp_plain(36, exp_t)); end
    if (mem[37] !== 8'(exp_plain(37, exp_t))) begin errors++; $display("[TB] FAIL par_dm37: got %0h need %0h", mem[37], exp_plain(37, exp_t)); end
  endtask

  task automatic test_random();
    int cyc;
    bit to;
    int exp_t;
    int exp_par;
    for (int r = 0; r < 6; r++) begin
      fill_random_pt();
      if (r % 2 == 1) pt[$urandom_range(1, PRE - 1)] = int'($urandom_range(33, 126));
      build(int'($urandom_range(0, 8)), int'($urandom_range(1, 127)));
      repeat ($urandom_range(0, 3)) begin
        int a = SRC + int'($urandom_range(0, LEN - 1));
        load_buf[a] = load_buf[a] ^ 8'h80;
      end
      load_mem();
      run(cyc, to);
      exp_t   = model_tap();
      exp_par = (exp_t >= 0) ? model_par() : 0;
      checks += 4;
      if (Found !== 1'(exp_t >= 0)) begin errors++; $display("[TB] FAIL rand_found[%0d]: got %0b need %0b", r, Found, exp_t >= 0); end
      if (TapSel !== ((exp_t >= 0) ? 4'(exp_t) : 4'hF)) begin errors++; $display("[TB] FAIL rand_tapsel[%0d]: got %0h model tap %0d", r, TapSel, exp_t); end
      if (((exp_t >= 0) ? bad_plain(exp_t) : changed_dst()) !== 0) begin errors++; $display("[TB] FAIL rand_dst[%0d]: got wrong bytes, need 0 (model tap %0d)", r, exp_t); end
      if (ParErrCnt !== 7'(exp_par)) begin errors++; $display("[TB] FAIL rand_parcnt[%0d]: got %0d need %0d", r, ParErrCnt, exp_par); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit to;
    bit hit = 1'b0;
    fill_random_pt();
    build(int'($urandom_range(0, 8)), int'($urandom_range(1, 127)));
    load_mem();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      tick();
      hit = (MemWrEn === 1'b1) && (MemAddr === 8'(DST + 20));
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL midrun_reach: DEC_WR at i=20 not seen, need seen"); end
    Reset = 1'b0;
    Start = 1'b1;
    tick();
    checks += 4;
    if (Ack !== 1'b0)     begin errors++; $display("[TB] FAIL midrun_ack: got %0b need 0", Ack); end
    if (MemWrEn !== 1'b0) begin errors++; $display("[TB] FAIL midrun_wren: got %0b need 0", MemWrEn); end
    if (TapSel !== 4'hF)  begin errors++; $display("[TB] FAIL midrun_tapsel: got %0h need f", TapSel); end
    if (Found !== 1'b0)   begin errors++; $display("[TB] FAIL midrun_found: got %0b need 0", Found); end
    Reset = 1'b1;
    tick();
    run(cyc, to);
    checks += 2;
    if (TapSel !== 4'(model_tap())) begin errors++; $display("[TB] FAIL relaunch_tapsel: got %0d need %0d", TapSel, model_tap()); end
    if (bad_plain(model_tap()) !== 0) begin errors++; $display("[TB] FAIL relaunch_bytes: %0d wrong bytes, need 0", bad_plain(model_tap())); end
  endtask

  initial begin
    Reset    = 1'b0;
    Start    = 1'b1;
    load_req = 1'b0;
    $display("[TB] lfsr_decrypt_sequencer bench starting");
    test_reset();
    test_start_hold();
    test_known_message();
    test_all_taps();
    test_zero_seed();
    test_parity();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
